conv_result_stream_tx: RTL
==========================

// Module: conv_result_stream_tx
// PURPOSE
//  AXI4-Stream master at the output end of the Conv2D3x3 datapath. Accepts one result word
//  per accepted beat from the conv core on a valid/ready push port and buffers it in a FIFO.
//  Emits results as a framed AXI4-Stream: tuser=start of frame, tlast=end of frame.
//  It is the transmit counterpart of the AXI4-Stream slave loaders (kernel/feature inputs).
// PARAMETERS
//  WIDTH       16   result word width, bits
//  FIFO_DEPTH  16   total buffering in words, output register included; power of 2, >=2
//  OUT_W       62   output frame width, pixels
//  OUT_H       62   output frame height, rows; frame = OUT_W*OUT_H beats
// PORTS
//  i_aclk          in   1      clock, all logic on rising edge
//  i_aresetn       in   1      asynchronous active-low reset
//  i_valid         in   1      core result valid
//  o_ready         out  1      space available; push happens when i_valid && o_ready
//  i_data          in   WIDTH  core result word
//  o_tvalid        out  1      AXI4-Stream master valid
//  i_tready        in   1      downstream ready; beat transfers when o_tvalid && i_tready
//  o_tdata         out  WIDTH  stream data
//  o_tuser         out  1      high on the first beat of each frame (row 0, col 0)
//  o_tlast         out  1      high on the last beat of each frame (row OUT_H-1, col OUT_W-1)
//  o_frame_done    out  1      one-cycle pulse the cycle after a tlast beat transfers
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, o_tvalid=0, o_tdata=0, o_tuser=0,
//    o_tlast=0, o_frame_done=0, o_ready=1, col/row counters=0.
//  - o_ready = (occupancy < FIFO_DEPTH), registered. No combinational path i_tready->o_ready.
//  - Occupancy counts FIFO words plus the output register. Push and pop in the same cycle
//    leave occupancy unchanged. At occupancy==FIFO_DEPTH a pop frees space next cycle.
//  - Latency: a word pushed into an empty block appears on o_tvalid/o_tdata at the next edge.
//    Throughput is 1 beat/cycle when i_valid and i_tready are held high.
//  - AXI rule: once o_tvalid=1, o_tdata/o_tuser/o_tlast hold until the beat transfers.
//    o_tvalid never drops without a transfer.
//  - Output register loads from the FIFO head when empty or when the current beat transfers.
//    Word order is strictly preserved.
//  - Framing counters (col 0..OUT_W-1, row 0..OUT_H-1) advance on each transferred beat.
//    col wraps to 0 and row increments. After col=OUT_W-1 with row=OUT_H-1, both reset to 0.
//    tuser/tlast come from the counter position of the beat being loaded into the output
//    register; they are not stored in the FIFO.
//  - o_frame_done pulses exactly once per frame, the cycle after the tlast transfer.
//  - Reset asserted mid-frame: buffered data is discarded and framing restarts at (0,0).
//  - i_data is ignored when the push is not accepted. The core must hold i_data while
//    i_valid && !o_ready.
//  - Width: WIDTH-bit data is passed unmodified; no truncation or rounding here.
//    Counter widths are $clog2(OUT_W) and $clog2(OUT_H), minimum 1.
// STRUCTURE
//  - Shared header conv_defs.vh: default WIDTH, OUT_W/OUT_H derivation (IN_W-2, IN_H-2),
//    and a CLOG2_MIN1 macro.
//  - Sub-module: stream_fifo (sync FIFO, BRAM/LUTRAM inferable, count output).
//    It holds FIFO_DEPTH-1 words.
//  - Top: output register stage, occupancy/o_ready logic, framing counters, frame_done.
// TESTING
//  1 Reset: hold i_aresetn=0 with random inputs -> every output at its reset value,
//    o_ready=1 within the reset; release -> no spurious beat.
//  2 Streaming: OUT_W=4, OUT_H=2, push 0..7 with i_tready=1 -> tdata 0..7 back-to-back.
//    tuser on beat 0 only, tlast on beat 7 only, frame_done 1 cycle later.
//  3 Backpressure: i_tready=0, push until o_ready=0 -> exactly FIFO_DEPTH (16) pushes accepted.
//    tdata stable; release i_tready -> 16 words out in order, no loss or duplication.
//  4 Full + simultaneous: at occupancy 16, toggle i_tready randomly with continuous i_valid
//    -> occupancy never exceeds 16, sequence intact. Scoreboard against a reference queue.
//  5 Multi-frame: 3 frames of 8 beats with random valid/ready gaps -> tuser at beats 0,8,16.
//    tlast at 7,15,23; three frame_done pulses.
//  6 Mid-frame reset: assert i_aresetn after beat 5 of 8 -> outputs clear asynchronously.
//    Next frame's first beat carries tuser=1.

Source files
------------

// File: rtl/conv_result_stream_tx_pkg.sv
// Shared definitions for the conv result stream transmitter.
// Holds the default geometry of the Conv2D3x3 output (a 3x3 valid convolution
// shrinks each input dimension by two) and a width helper for counters and
// pointers that must be at least one bit wide.
package conv_result_stream_tx_pkg;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_IN_W       = 64;
  localparam int DEFAULT_IN_H       = 64;
  localparam int DEFAULT_OUT_W      = DEFAULT_IN_W - 2;
  localparam int DEFAULT_OUT_H      = DEFAULT_IN_H - 2;

  // $clog2 returns 0 for 1, which would give a zero-width counter.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/conv_result_stream_tx_if.sv
// Handshake bundle of the conv result stream transmitter.
//   push side  : i_valid, o_ready, i_data            (from the conv core)
//   stream side: o_tvalid, i_tready, o_tdata, o_tuser, o_tlast, o_frame_done
// modport master: the transmitter itself; modport slave: core plus downstream sink.
interface conv_result_stream_tx_if
  import conv_result_stream_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tuser;
  logic             o_tlast;
  logic             o_frame_done;

  modport master (
    input  i_valid, i_data, i_tready,
    output o_ready, o_tvalid, o_tdata, o_tuser, o_tlast, o_frame_done
  );

  modport slave (
    output i_valid, i_data, i_tready,
    input  o_ready, o_tvalid, o_tdata, o_tuser, o_tlast, o_frame_done
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with first-word-fall-through read (rd_data shows the head
// whenever the FIFO is not empty). Storage has no reset so it maps onto LUTRAM.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en, wr_data    write one word (caller guarantees not full)
//   rd_en             pop the head word (caller guarantees not empty)
//   rd_data           current head word
//   count, empty      number of stored words, count == 0
module stream_fifo
  import conv_result_stream_tx_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_FIFO_DEPTH - 1,
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is deliberately left without reset; pointers and count
  // define which entries are meaningful, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/conv_result_stream_tx.sv
// AXI4-Stream master at the output of the Conv2D3x3 datapath.
// Results pushed by the core are buffered (FIFO of FIFO_DEPTH-1 words plus the
// output register) and emitted as a framed stream: o_tuser marks (row 0, col 0),
// o_tlast marks (OUT_H-1, OUT_W-1), o_frame_done pulses the cycle after tlast.
// Ports:
//   i_aclk, i_aresetn  clock, async active-low reset
//   bus (master)       push port i_valid/o_ready/i_data and stream port
//                      o_tvalid/i_tready/o_tdata/o_tuser/o_tlast/o_frame_done
module conv_result_stream_tx
  import conv_result_stream_tx_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int OUT_W      = DEFAULT_OUT_W,
  parameter int OUT_H      = DEFAULT_OUT_H
) (
  input  logic                   i_aclk,
  input  logic                   i_aresetn,
  conv_result_stream_tx_if.master bus
);

  localparam int COL_W  = clog2_min1(OUT_W);
  localparam int ROW_W  = clog2_min1(OUT_H);
  localparam int FCNT_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic              ready_q;
  logic              tvalid_q;
  logic [WIDTH-1:0]  tdata_q;
  logic              tuser_q;
  logic              tlast_q;
  logic              done_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;

  logic              push;
  logic              pop;
  logic              load;
  logic              take_fifo;
  logic              take_bypass;
  logic              fifo_wr;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]  occ_next;
  logic              at_first;
  logic              at_last;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH - 1)
  ) u_fifo (
    .clk     (i_aclk),
    .rst_n   (i_aresetn),
    .wr_en   (fifo_wr),
    .wr_data (bus.i_data),
    .rd_en   (take_fifo),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // NOTE: every signal is assigned unconditionally in this block, so no
  // path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    push = bus.i_valid && ready_q;
    pop  = tvalid_q && bus.i_tready;
    load = !tvalid_q || pop;
    // The FIFO is only non-empty while the output register is full, so a
    // word arriving at an idle block skips the FIFO and lands in the
    // register at the next edge; otherwise it queues behind the FIFO head.
    take_fifo   = load && !fifo_empty;
    take_bypass = load && fifo_empty && push;
    fifo_wr     = push && !take_bypass;
    occ_next    = OCC_W'(fifo_count) + OCC_W'(tvalid_q)
                + OCC_W'(push) - OCC_W'(pop);
    at_first    = (col_q == '0) && (row_q == '0);
    at_last     = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  // col/row track the position of the next word to enter the output
  // register. Every loaded word leaves as a transfer before any later one,
  // so this equals counting transfers while giving the loaded beat its
  // position directly.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ready_q  <= 1'b1;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      // Registered from the next occupancy: no i_tready -> o_ready path.
      ready_q <= (occ_next < OCC_FULL);
      done_q  <= pop && tlast_q;
      if (take_fifo || take_bypass) begin
        tvalid_q <= 1'b1;
        tdata_q  <= take_fifo ? fifo_head : bus.i_data;
        tuser_q  <= at_first;
        tlast_q  <= at_last;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end else if (pop) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_tvalid     = tvalid_q;
  assign bus.o_tdata      = tdata_q;
  assign bus.o_tuser      = tuser_q;
  assign bus.o_tlast      = tlast_q;
  assign bus.o_frame_done = done_q;

endmodule
